demux_1_4_tdm: RTL and testbench
================================

// Module: demux_1_4_tdm
// PURPOSE
//  Registered 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 mux path.
//  Routes a single valid/ready input stream to one of four output channels.
//  The channel is picked by an explicit select (MODE_SEL) or by an internal
//  round-robin slot counter (MODE_TDM), which undoes a time-division-multiplexed stream.
//  Each channel has a one-entry holding register, so one stalled consumer blocks only
//  words addressed to that channel.
// PARAMETERS
//  W        8   data width per word
//  CNT_W    8   width of the per-channel delivered-word counters
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous reset, active-high
//  mode        in   1        0 = MODE_SEL (route by in_sel); 1 = MODE_TDM (route by slot counter)
//  in_valid    in   1        input word valid
//  in_ready    out  1        input word accepted when in_valid & in_ready
//  in_data     in   W        input word
//  in_sel      in   2        target channel (used in MODE_SEL only)
//  out_valid   out  4        per-channel holding register full
//  out_ready   in   4        per-channel consumer ready
//  out_data    out  4*W      channel k occupies out_data[k*W +: W]
//  slot        out  2        current TDM slot counter value
//  cnt_flat    out  4*CNT_W  channel k delivered-word count at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (sync, takes priority over all events):
//    out_valid=0, out_data=0, slot=0, every counter=0; in_ready follows the rule below (=1 after reset).
//  - Target channel: tgt = mode ? slot : in_sel. This is combinational. The slot counter is sampled
//    before any update in the same cycle.
//  - in_ready = ~out_valid[tgt] | out_ready[tgt]. This is combinational. A full channel accepts a new
//    word in the same cycle its old word drains.
//  - Accept (in_valid & in_ready): out_data[tgt] <= in_data and out_valid[tgt] <= 1 on the next edge.
//    Latency is 1 cycle from input to output.
//  - Drain channel k (out_valid[k] & out_ready[k]):
//    - If channel k is not loaded in the same cycle, out_valid[k] <= 0. out_data[k] holds its last value.
//    - A simultaneous drain and load on the same channel leaves out_valid[k]=1 with the new data.
//  - Channels other than tgt are never loaded. They drain independently, in parallel, in any cycle.
//  - Slot counter:
//    - Increments mod 4 (3 -> 0) on every accepted word in MODE_TDM.
//    - Holds on stall (in_valid & ~in_ready) and holds in MODE_SEL.
//    - Does not reset when mode changes; only rst clears it.
//  - Counters: cnt[k] increments on each drain of channel k and wraps 2^CNT_W-1 -> 0.
//  - Output stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is stable.
//  - No combinational path from in_valid or in_data to any out_* signal.
//  - A reset that lands mid-stream discards every held word. No partial or late delivery of words
//    held before reset.
// TESTING
//  1. MODE_SEL, out_ready=4'hF, sel=2 with data 8'hA5 -> next cycle out_valid=4'b0100, ch2=A5;
//     the cycle after, out_valid=0 and cnt2=1.
//  2. MODE_TDM, all ready, stream 11,22,33,44,55 -> ch0..ch3 get 11,22,33,44 in order, then ch0=55;
//     slot reads 1 at end.
//  3. MODE_SEL, ch1 full with out_ready[1]=0, send to ch1 -> in_ready=0 and ch1 data held;
//     a send to ch3 in the same phase is accepted.
//  4. ch0 full; in one cycle out_ready[0]=1 and a new word 8'h3C sent to ch0 -> accepted,
//     out_valid[0] stays 1, ch0=3C, cnt0 +1.
//  5. MODE_TDM stall on slot 2 (ch2 blocked) for 5 cycles -> slot stays 2; release ch2 ->
//     word delivered and slot becomes 3.
//  6. Hold out_ready[0]=1 across 257 ch0 deliveries with CNT_W=8 -> cnt0 wraps to 1.
//     Then assert rst mid-stream with words held -> all out_valid=0, counters=0, slot=0
//     on the next edge.

Source files
------------

// File: rtl/demux_1_4_tdm.sv
// Purpose    : 1-to-4 demux of a valid/ready word stream; channel chosen by in_sel or by a TDM slot counter.
// Latency    : 1 cycle from an accepted input word to out_valid/out_data of its channel.
// Backpressure: in_ready drops only while the targeted channel is full and its consumer is stalled.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mode                0 = route by in_sel, 1 = route by internal slot counter
//   in_valid/in_ready   input handshake; in_data is the word, in_sel the explicit target
//   out_valid/out_ready per-channel handshake; channel k data at out_data[k*W +: W]
//   slot                current TDM slot (target channel when mode = 1)
//   cnt_flat            per-channel delivered-word counters, channel k at [k*CNT_W +: CNT_W]
module demux_1_4_tdm #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data,
  output logic [1:0]       slot,
  output logic [4*CNT_W-1:0] cnt_flat
);

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  logic [W-1:0]     data_q [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [3:0]       vld_q;
  logic [1:0]       slot_q;

  logic [1:0]       tgt;
  logic             accept;
  logic [3:0]       drain;
  logic [3:0]       load;

  // The slot register is read here before its own update, so the word
  // accepted in this cycle goes to the current slot, not the next one.
  assign tgt      = (mode == MODE_TDM) ? slot_q : in_sel;

  // A full channel can still take a word in the cycle its consumer drains it.
  assign in_ready = ~vld_q[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    drain = vld_q & out_ready;
    load  = 4'b0000;
    if (accept) begin
      load[tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 4'b0000;
      slot_q <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // Load wins over drain: a simultaneous drain+load keeps the channel
        // full with the new word.
        if (load[k]) begin
          data_q[k] <= in_data;
          vld_q[k]  <= 1'b1;
        end else if (drain[k]) begin
          vld_q[k]  <= 1'b0;
        end
        if (drain[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
      // Slot only moves on accepted TDM words; a stall or MODE_SEL holds it,
      // and a mode change alone never clears it.
      if (accept && (mode == MODE_TDM)) begin
        slot_q <= slot_q + 2'd1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    cnt_flat = '0;
    for (int k = 0; k < 4; k++) begin
      out_data[k*W +: W]         = data_q[k];
      cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign out_valid = vld_q;
  assign slot      = slot_q;

endmodule

// File: tb/tb_demux_1_4_tdm.sv
// Purpose    : directed self-checking bench for demux_1_4_tdm.
// Latency    : inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: out_ready patterns are driven per test to stall individual channels.
module tb_demux_1_4_tdm;

  localparam int W     = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*W-1:0]   out_data;
  logic [1:0]       slot;
  logic [4*CNT_W-1:0] cnt_flat;

  int n_checks = 0;
  int n_errors = 0;

  demux_1_4_tdm #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .slot      (slot),
    .cnt_flat  (cnt_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a word, let combinational in_ready settle.
  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
    #1;
  endtask

  function automatic logic [7:0] ch(input int k);
    return out_data[k*W +: W];
  endfunction

  function automatic logic [7:0] cnt(input int k);
    return cnt_flat[k*CNT_W +: CNT_W];
  endfunction

  initial begin
    logic [7:0] stream [5];
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    stream[3] = 8'h44; stream[4] = 8'h55;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'hF;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_slot",      {30'd0, slot}, 32'd0);
    chk("rst_cnt",       cnt_flat, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // 1: explicit select to channel 2
    drive(1'b1, 2'd2, 8'hA5);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("t1_out_valid", {28'd0, out_valid}, 32'h4);
    chk("t1_ch2",       {24'd0, ch(2)}, 32'hA5);
    step();
    chk("t1_drained",   {28'd0, out_valid}, 32'h0);
    chk("t1_cnt2",      {24'd0, cnt(2)}, 32'd1);

    // 2: TDM stream walks slots 0,1,2,3,0
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, stream[i]);
      step();
      chk($sformatf("t2_vld_%0d", i), {28'd0, out_valid}, 32'(1 << (i % 4)));
      chk($sformatf("t2_dat_%0d", i), {24'd0, ch(i % 4)}, {24'd0, stream[i]});
    end
    drive(1'b0, 2'd0, 8'h00);
    chk("t2_slot", {30'd0, slot}, 32'd1);
    step();
    chk("t2_cnt", cnt_flat, {8'd1, 8'd2, 8'd1, 8'd2});

    // 3: ch1 stalled blocks only ch1 traffic
    mode = 1'b0;
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h77);
    step();
    chk("t3_ch1_full", {28'd0, out_valid}, 32'h2);
    drive(1'b1, 2'd1, 8'h88);
    chk("t3_in_ready_blk", {31'd0, in_ready}, 32'd0);
    step();
    chk("t3_ch1_held", {24'd0, ch(1)}, 32'h77);
    chk("t3_ch1_vld",  {31'd0, out_valid[1]}, 32'd1);
    drive(1'b1, 2'd3, 8'h9A);
    chk("t3_in_ready_ch3", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("t3_vld_13", {28'd0, out_valid}, 32'hA);
    chk("t3_ch3",    {24'd0, ch(3)}, 32'h9A);
    chk("t3_ch1_still", {24'd0, ch(1)}, 32'h77);
    step();
    chk("t3_ch3_drained", {28'd0, out_valid}, 32'h2);
    out_ready = 4'hF;
    step();
    chk("t3_all_drained", {28'd0, out_valid}, 32'h0);
    chk("t3_cnt", cnt_flat, {8'd2, 8'd2, 8'd2, 8'd2});

    // 4: simultaneous drain and reload on ch0
    out_ready = 4'h0;
    drive(1'b1, 2'd0, 8'h5A);
    step();
    chk("t4_ch0_full", {28'd0, out_valid}, 32'h1);
    out_ready = 4'h1;
    drive(1'b1, 2'd0, 8'h3C);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("t4_vld",  {28'd0, out_valid}, 32'h1);
    chk("t4_ch0",  {24'd0, ch(0)}, 32'h3C);
    chk("t4_cnt0", {24'd0, cnt(0)}, 32'd3);

    // 5: TDM stall on slot 2
    out_ready = 4'b1011;
    mode = 1'b0;
    drive(1'b1, 2'd2, 8'hD0);
    step();
    mode = 1'b1;
    chk("t5_slot_start", {30'd0, slot}, 32'd1);
    drive(1'b1, 2'd0, 8'hB1);
    step();
    chk("t5_slot2", {30'd0, slot}, 32'd2);
    drive(1'b1, 2'd0, 8'hE2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_stall_rdy_%0d", i), {31'd0, in_ready}, 32'd0);
      step();
      chk($sformatf("t5_stall_slot_%0d", i), {30'd0, slot}, 32'd2);
    end
    chk("t5_ch2_held", {24'd0, ch(2)}, 32'hD0);
    out_ready = 4'hF;
    #1;
    chk("t5_release_rdy", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    chk("t5_ch2_new", {24'd0, ch(2)}, 32'hE2);
    chk("t5_ch2_vld", {31'd0, out_valid[2]}, 32'd1);
    chk("t5_slot3",   {30'd0, slot}, 32'd3);
    step();
    chk("t5_cnt2", {24'd0, cnt(2)}, 32'd4);

    // 6: counter wrap, then reset with words held
    rst = 1'b1;
    step();
    rst = 1'b0;
    mode = 1'b0;
    out_ready = 4'h1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'd0, 8'(i));
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    chk("t6_cnt0_wrap", {24'd0, cnt(0)}, 32'd1);
    chk("t6_ch0_last",  {24'd0, ch(0)}, 32'h00);

    mode = 1'b1;
    out_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 8'hC0 + 8'(i));
      step();
    end
    chk("t6_held_vld", {28'd0, out_valid}, 32'h7);
    chk("t6_held_slot", {30'd0, slot}, 32'd3);
    rst = 1'b1;
    out_ready = 4'hF;
    drive(1'b1, 2'd0, 8'hEE);
    step();
    chk("t6_rst_vld",  {28'd0, out_valid}, 32'h0);
    chk("t6_rst_cnt",  cnt_flat, 32'd0);
    chk("t6_rst_slot", {30'd0, slot}, 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    step();
    chk("t6_no_late_vld", {28'd0, out_valid}, 32'h0);
    chk("t6_no_late_cnt", cnt_flat, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
